// File: rtl/byte_link_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : byte_link_arbiter_pkg
//  Brief    : Shared state encoding, parameter defaults and helpers for the
//             two-consumer byte link arbiter.
//  Revision : 1.0
// ============================================================================
package byte_link_arbiter_pkg;

    localparam int c_FRAME_LEN_DEF = 40;
    localparam int c_TIMEOUT_DEF   = 1024;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_REQ     = 3'd1;
    localparam logic [2:0] c_ST_HOLD    = 3'd2;
    localparam logic [2:0] c_ST_RELEASE = 3'd3;
    localparam logic [2:0] c_ST_COUNT   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_REQ     = c_ST_REQ,
        ST_HOLD    = c_ST_HOLD,
        ST_RELEASE = c_ST_RELEASE,
        ST_COUNT   = c_ST_COUNT
    } state_t;

    function automatic logic [1:0] onehot2(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_link_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Combinational 2-way round-robin pick; i_last names the consumer
//             served most recently, which loses a simultaneous request.
//  Revision : 1.0
// ============================================================================
module rr_arb2
    import byte_link_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = onehot2(~i_last);
            default: o_gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/byte_link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : byte_link_arbiter
//  Brief    : Grants a frame of FRAME_LEN bytes from one upstream source to one
//             of two consumers using four-phase handshakes on both sides.
//  Revision : 1.0
// ============================================================================
module byte_link_arbiter
    import byte_link_arbiter_pkg::*;
#(
    parameter int FRAME_LEN = c_FRAME_LEN_DEF,
    parameter int TIMEOUT   = c_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] c_req,
    input  logic [1:0] c_ack,
    output logic [1:0] c_ready,
    output logic [7:0] c_byte,
    output logic [1:0] grant,
    output logic       up_req,
    input  logic       up_ready,
    input  logic [7:0] up_byte,
    output logic       up_ack,
    output logic [5:0] byte_idx,
    output logic       frame_done,
    output logic       err,
    input  logic       err_clr
);

    localparam logic [5:0]  c_LAST_IDX = 6'(FRAME_LEN - 1);
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nxt;
    logic [5:0]  r_idx;
    logic [5:0]  w_idx_nxt;
    logic [15:0] r_tmo;
    logic [15:0] w_tmo_nxt;
    logic [7:0]  r_byte;
    logic [7:0]  w_byte_nxt;
    logic        r_last;
    logic        w_last_nxt;
    logic        r_err;
    logic        w_tmo_hit;
    logic [1:0]  w_pick;
    logic        w_req_g;
    logic        w_ack_g;

    rr_arb2 u_rr_arb2 (
        .i_req  (c_req),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    // Only the granted consumer's request and acknowledge are ever observed.
    assign w_req_g = |(c_req & r_grant);
    assign w_ack_g = |(c_ack & r_grant);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_idx   <= 6'd0;
            r_tmo   <= 16'd0;
            r_byte  <= 8'h00;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_idx   <= w_idx_nxt;
            r_tmo   <= w_tmo_nxt;
            r_byte  <= w_byte_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_tmo_hit | (r_err & ~err_clr);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        w_tmo_nxt   = r_tmo;
        w_byte_nxt  = r_byte;
        w_last_nxt  = r_last;
        w_tmo_hit   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_idx_nxt = 6'd0;
                w_tmo_nxt = 16'd0;
                if (|c_req) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ST_REQ;
                end
            end

            ST_REQ: begin
                // A byte arriving wins over a simultaneous request drop.
                if (up_ready) begin
                    w_byte_nxt  = up_byte;
                    w_state_nxt = ST_HOLD;
                end else if (!w_req_g || (r_tmo == c_TMO_LAST)) begin
                    w_tmo_hit   = w_req_g;
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 2'b00;
                    w_idx_nxt   = 6'd0;
                    w_tmo_nxt   = 16'd0;
                end else begin
                    w_tmo_nxt = r_tmo + 16'd1;
                end
            end

            ST_HOLD: begin
                if (w_ack_g) begin
                    w_state_nxt = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (!up_ready && !w_ack_g) begin
                    w_state_nxt = ST_COUNT;
                end
            end

            ST_COUNT: begin
                w_tmo_nxt = 16'd0;
                if (r_idx == c_LAST_IDX) begin
                    w_last_nxt  = r_grant[1];
                    w_grant_nxt = 2'b00;
                    w_idx_nxt   = 6'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_idx_nxt   = r_idx + 6'd1;
                    w_state_nxt = ST_REQ;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
                w_idx_nxt   = 6'd0;
                w_tmo_nxt   = 16'd0;
            end
        endcase
    end

    assign grant      = r_grant;
    assign c_byte     = r_byte;
    assign byte_idx   = r_idx;
    assign err        = r_err;
    assign c_ready    = (r_state == ST_HOLD) ? r_grant : 2'b00;
    assign up_req     = (r_state == ST_REQ) || (r_state == ST_HOLD);
    assign up_ack     = (r_state == ST_RELEASE);
    assign frame_done = (r_state == ST_COUNT) && (r_idx == c_LAST_IDX);

endmodule
`default_nettype wire

// File: tb/tb_byte_link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_byte_link_arbiter
//  Brief    : Directed self-checking bench for byte_link_arbiter.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_byte_link_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] c_req;
    logic [1:0] c_ack;
    logic [1:0] c_ready;
    logic [7:0] c_byte;
    logic [1:0] grant;
    logic       up_req;
    logic       up_ready;
    logic [7:0] up_byte;
    logic       up_ack;
    logic [5:0] byte_idx;
    logic       frame_done;
    logic       err;
    logic       err_clr;

    int n_vec = 0;
    int n_err = 0;

    byte_link_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .c_req      (c_req),
        .c_ack      (c_ack),
        .c_ready    (c_ready),
        .c_byte     (c_byte),
        .grant      (grant),
        .up_req     (up_req),
        .up_ready   (up_ready),
        .up_byte    (up_byte),
        .up_ack     (up_ack),
        .byte_idx   (byte_idx),
        .frame_done (frame_done),
        .err        (err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0:       return up_req;
            default: return up_ack;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        int n;
        n = 0;
        while (!cond(sel) && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_wait"}, 32'(cond(sel)), 32'd1);
    endtask

    // One full byte handshake to consumer c; ends observing the COUNT cycle.
    task automatic xfer(input int c, input logic [7:0] b, input logic [5:0] idx, input logic last);
        logic [1:0] oh;
        oh = (c == 0) ? 2'b01 : 2'b10;
        wait_for(0, "up_req");
        chk("byte_idx", 32'(byte_idx), 32'(idx));
        chk("grant", 32'(grant), 32'(oh));
        up_ready = 1'b1;
        up_byte  = b;
        step();
        chk("c_ready", 32'(c_ready), 32'(oh));
        chk("c_byte", 32'(c_byte), 32'(b));
        c_ack = oh;
        step();
        chk("up_ack", 32'(up_ack), 32'd1);
        up_ready = 1'b0;
        c_ack    = 2'b00;
        step();
        chk("frame_done", 32'(frame_done), 32'(last));
    endtask

    task automatic frame(input int c, input logic [7:0] base);
        for (int i = 0; i < 40; i++) begin
            xfer(c, base + 8'(i), 6'(i), i == 39);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic saw_bad;
        rst = 1'b0; c_req = 2'b00; c_ack = 2'b00;
        up_ready = 1'b0; up_byte = 8'h00; err_clr = 1'b0;
        repeat (3) step();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_c_ready", 32'(c_ready), 32'd0);
        chk("rst_up_req", 32'(up_req), 32'd0);
        chk("rst_up_ack", 32'(up_ack), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_byte_idx", 32'(byte_idx), 32'd0);
        chk("rst_c_byte", 32'(c_byte), 32'd0);
        rst = 1'b1;
        step();
        chk("idle_grant", 32'(grant), 32'd0);

        // Single consumer frame
        c_req = 2'b01;
        step();
        chk("single_grant", 32'(grant), 32'd1);
        chk("single_up_req", 32'(up_req), 32'd1);
        frame(0, 8'h00);
        c_req = 2'b00;
        step();
        chk("single_end_grant", 32'(grant), 32'd0);
        chk("single_fd_once", 32'(frame_done), 32'd0);

        // Contention from reset: consumer 0 first, then consumer 1
        rst = 1'b0;
        step();
        rst = 1'b1;
        c_req = 2'b11;
        step();
        chk("cont_first", 32'(grant), 32'd1);
        frame(0, 8'h80);
        step();
        chk("cont_gap", 32'(grant), 32'd0);
        step();
        chk("cont_second", 32'(grant), 32'd2);
        frame(1, 8'hC0);
        c_req = 2'b00;
        step();
        chk("cont_end", 32'(grant), 32'd0);

        // Timeout
        c_req = 2'b01;
        step();
        saw_bad = 1'b0;
        repeat (1023) begin
            step();
            saw_bad = saw_bad | frame_done | err;
        end
        chk("tmo_pre_up_req", 32'(up_req), 32'd1);
        chk("tmo_pre_err", 32'(err), 32'd0);
        step();
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_up_req", 32'(up_req), 32'd0);
        chk("tmo_grant", 32'(grant), 32'd0);
        chk("tmo_no_fd", 32'(saw_bad | frame_done), 32'd0);
        c_req = 2'b00;
        step();
        chk("tmo_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("tmo_clr", 32'(err), 32'd0);

        // Abort in REQ at byte 5
        c_req = 2'b01;
        step();
        for (int i = 0; i < 5; i++) xfer(0, 8'h10 + 8'(i), 6'(i), 1'b0);
        step();
        chk("abort_idx", 32'(byte_idx), 32'd5);
        chk("abort_up_req", 32'(up_req), 32'd1);
        c_req = 2'b00;
        step();
        chk("abort_grant", 32'(grant), 32'd0);
        chk("abort_up_req_off", 32'(up_req), 32'd0);
        chk("abort_idx_clr", 32'(byte_idx), 32'd0);
        chk("abort_no_fd", 32'(frame_done), 32'd0);

        // Drop during HOLD: byte still completes
        c_req = 2'b01;
        step();
        up_ready = 1'b1; up_byte = 8'h5A;
        step();
        c_req = 2'b00;
        step();
        chk("hold_drop_ready", 32'(c_ready), 32'd1);
        c_ack = 2'b01;
        step();
        chk("hold_drop_up_ack", 32'(up_ack), 32'd1);
        up_ready = 1'b0; c_ack = 2'b00;
        step();
        chk("hold_drop_grant", 32'(grant), 32'd1);
        step();
        chk("hold_drop_next_idx", 32'(byte_idx), 32'd1);
        step();
        chk("hold_drop_idle", 32'(grant), 32'd0);

        // Drop and up_ready in the same REQ cycle: byte wins
        c_req = 2'b01;
        step();
        up_ready = 1'b1; up_byte = 8'h3C; c_req = 2'b00;
        step();
        chk("tie_ready", 32'(c_ready), 32'd1);
        chk("tie_byte", 32'(c_byte), 32'h3C);
        c_ack = 2'b01;
        step();
        up_ready = 1'b0; c_ack = 2'b00;
        repeat (3) step();
        chk("tie_idle", 32'(grant), 32'd0);

        // Slow consumer, ungranted ack ignored, c_byte stable
        c_req = 2'b01;
        step();
        up_ready = 1'b1; up_byte = 8'hA5;
        step();
        up_byte = 8'h00;
        c_ack = 2'b10;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("slow_hold_ready", 32'(c_ready), 32'd1);
            chk("slow_hold_byte", 32'(c_byte), 32'hA5);
        end
        c_ack = 2'b01;
        step();
        for (int k = 0; k < 10; k++) begin
            chk("slow_up_ack", 32'(up_ack), 32'd1);
            chk("slow_up_req", 32'(up_req), 32'd0);
            chk("slow_c_ready", 32'(c_ready), 32'd0);
            if (k == 2) up_ready = 1'b0;
            step();
        end
        up_ready = 1'b1; c_ack = 2'b00;
        step();
        chk("slow_up_ready_hold", 32'(up_ack), 32'd1);
        up_ready = 1'b0;
        step();
        chk("slow_count_ack", 32'(up_ack), 32'd0);
        chk("slow_count_byte", 32'(c_byte), 32'hA5);
        c_req = 2'b00;
        repeat (2) step();
        chk("slow_idle", 32'(grant), 32'd0);

        // Reset mid-frame at byte 20
        c_req = 2'b01;
        step();
        for (int i = 0; i < 20; i++) xfer(0, 8'h40 + 8'(i), 6'(i), 1'b0);
        step();
        chk("mid_idx", 32'(byte_idx), 32'd20);
        up_ready = 1'b1; up_byte = 8'hEE; rst = 1'b0;
        step();
        chk("mid_grant", 32'(grant), 32'd0);
        chk("mid_c_ready", 32'(c_ready), 32'd0);
        chk("mid_up_req", 32'(up_req), 32'd0);
        chk("mid_up_ack", 32'(up_ack), 32'd0);
        chk("mid_idx_clr", 32'(byte_idx), 32'd0);
        chk("mid_c_byte", 32'(c_byte), 32'd0);
        chk("mid_fd", 32'(frame_done), 32'd0);
        rst = 1'b1; up_ready = 1'b0;
        step();
        chk("restart_grant", 32'(grant), 32'd1);
        chk("restart_up_req", 32'(up_req), 32'd1);
        xfer(0, 8'h99, 6'd0, 1'b0);
        c_req = 2'b00;
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
